ecc_io_ctrl: RTL

Bit-serial I/O controller for the ECC scalar-multiplication core. It parses the two serial input frames, the m·P frame (mode, a, b, prime, Px, Py, m) and the nP frame (nPx, nPy), into right-aligned parallel operand registers. It issues start pulses to the core when operands are complete, and serializes the core's parallel results back out MSB-first. It sits between the top-level pins and the core datapath.

---
 rtl/ecc_io_ctrl_if.sv | 66 ++++++
 rtl/ecc_io_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_io_ctrl_if.sv
// ecc_io_ctrl_if: pin/core-facing bundle for the ECC bit-serial I/O controller.
// Handshake semantics: every *_valid / *_done / o_start_* signal is a
// single-cycle strobe sampled on the rising clock edge. There is no
// backpressure (no ready). The payload is valid on the strobe edge: serial
// data follows its header, and parallel results are valid with done.
// dbg_state exposes the controller FSM states {mp_rx, np_rx, mp_ser, mnp_ser}.
interface ecc_io_ctrl_if #(
  parameter int MAX_BITS = 256
);
  logic                i_m_P_valid;
  logic                i_nP_valid;
  logic                i_mode;
  logic                i_a;
  logic                i_b;
  logic                i_prime;
  logic                i_Px;
  logic                i_Py;
  logic                i_m;
  logic                i_nPx;
  logic                i_nPy;
  logic [1:0]          o_mode;
  logic [MAX_BITS-1:0] o_a;
  logic [MAX_BITS-1:0] o_b;
  logic [MAX_BITS-1:0] o_prime;
  logic [MAX_BITS-1:0] o_Px;
  logic [MAX_BITS-1:0] o_Py;
  logic [MAX_BITS-1:0] o_m;
  logic [MAX_BITS-1:0] o_nPx;
  logic [MAX_BITS-1:0] o_nPy;
  logic                o_start_mP;
  logic                o_start_mnP;
  logic                i_mP_done;
  logic                i_mnP_done;
  logic [MAX_BITS-1:0] i_mPx;
  logic [MAX_BITS-1:0] i_mPy;
  logic [MAX_BITS-1:0] i_mnPx;
  logic [MAX_BITS-1:0] i_mnPy;
  logic                o_mP_valid;
  logic                o_mnP_valid;
  logic                o_mPx;
  logic                o_mPy;
  logic                o_mnPx;
  logic                o_mnPy;
  logic                o_err;
  logic [5:0]          dbg_state;

  // Controller side.
  modport slave (
    input  i_m_P_valid, i_nP_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py,
           i_m, i_nPx, i_nPy, i_mP_done, i_mnP_done, i_mPx, i_mPy, i_mnPx,
           i_mnPy,
    output o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy,
           o_start_mP, o_start_mnP, o_mP_valid, o_mnP_valid, o_mPx, o_mPy,
           o_mnPx, o_mnPy, o_err, dbg_state
  );

  // Pins/core side.
  modport master (
    output i_m_P_valid, i_nP_valid, i_mode, i_a, i_b, i_prime, i_Px, i_Py,
           i_m, i_nPx, i_nPy, i_mP_done, i_mnP_done, i_mPx, i_mPy, i_mnPx,
           i_mnPy,
    input  o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy,
           o_start_mP, o_start_mnP, o_mP_valid, o_mnP_valid, o_mPx, o_mPy,
           o_mnPx, o_mnPy, o_err, dbg_state
  );
endinterface

// File: rtl/ecc_io_ctrl.sv
// ecc_io_ctrl: bit-serial I/O controller for the ECC scalar-multiplication core.
// Deserializes the mP frame (mode, a, b, prime, Px, Py, m) and the nP frame
// (nPx, nPy) into right-aligned operand registers, issues start pulses, and
// serializes the core results MSB first. Frame length is 32 << mode.
// Optional macro ECC_IO_PROTOCOL_CHK_EN enables the sticky o_err checker;
// when undefined, o_err is tied low.
module ecc_io_ctrl #(
  parameter int MAX_BITS = 256
) (
  input logic          clk,
  input logic          rst,
  ecc_io_ctrl_if.slave io
);

  typedef enum logic [1:0] {MP_IDLE, MP_MODE_HI, MP_MODE_LO, MP_DATA} mp_state_t;
  typedef enum logic [1:0] {NP_IDLE, NP_GAP, NP_DATA} np_state_t;
  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  mp_state_t           mp_state;
  np_state_t           np_state;
  ser_state_t          mp_ser_state;
  ser_state_t          mnp_ser_state;
  logic [7:0]          mp_cnt;
  logic [7:0]          np_cnt;
  logic [7:0]          mp_ser_cnt;
  logic [7:0]          mnp_ser_cnt;
  logic [MAX_BITS-1:0] mp_sx;
  logic [MAX_BITS-1:0] mp_sy;
  logic [MAX_BITS-1:0] mnp_sx;
  logic [MAX_BITS-1:0] mnp_sy;
  logic                mp_rdy;
  logic                np_rdy;
  logic                mp_last;
  logic                np_last;
  logic [7:0]          ser_last;

  // Index of the first (MSB) bit of a frame: N-1 with N = 32 << mode.
  function automatic logic [7:0] last_idx(input logic [1:0] m);
    case (m)
      2'd0:    last_idx = 8'd31;
      2'd1:    last_idx = 8'd63;
      2'd2:    last_idx = 8'd127;
      default: last_idx = 8'd255;
    endcase
  endfunction

  assign mp_last   = (mp_state == MP_DATA) && (mp_cnt == 8'd0);
  assign np_last   = (np_state == NP_DATA) && (np_cnt == 8'd0);
  assign ser_last  = last_idx(io.o_mode);
  assign io.dbg_state = {mp_state, np_state, mp_ser_state, mnp_ser_state};

  // mP frame receiver: two mode bits, then N data bits shifted in MSB first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mp_state   <= MP_IDLE;
      mp_cnt     <= '0;
      io.o_mode  <= '0;
      io.o_a     <= '0;
      io.o_b     <= '0;
      io.o_prime <= '0;
      io.o_Px    <= '0;
      io.o_Py    <= '0;
      io.o_m     <= '0;
    end else begin
      case (mp_state)
        MP_IDLE: begin
          if (io.i_m_P_valid) mp_state <= MP_MODE_HI;
        end
        MP_MODE_HI: begin
          io.o_mode[1] <= io.i_mode;
          mp_state     <= MP_MODE_LO;
        end
        MP_MODE_LO: begin
          io.o_mode[0] <= io.i_mode;
          // The new mode is not registered yet, so size the frame from the
          // freshly sampled bit.
          mp_cnt       <= last_idx({io.o_mode[1], io.i_mode});
          io.o_a       <= '0;
          io.o_b       <= '0;
          io.o_prime   <= '0;
          io.o_Px      <= '0;
          io.o_Py      <= '0;
          io.o_m       <= '0;
          mp_state     <= MP_DATA;
        end
        MP_DATA: begin
          io.o_a     <= {io.o_a[MAX_BITS-2:0], io.i_a};
          io.o_b     <= {io.o_b[MAX_BITS-2:0], io.i_b};
          io.o_prime <= {io.o_prime[MAX_BITS-2:0], io.i_prime};
          io.o_Px    <= {io.o_Px[MAX_BITS-2:0], io.i_Px};
          io.o_Py    <= {io.o_Py[MAX_BITS-2:0], io.i_Py};
          io.o_m     <= {io.o_m[MAX_BITS-2:0], io.i_m};
          if (mp_cnt == 8'd0) mp_state <= MP_IDLE;
          else                mp_cnt   <= mp_cnt - 8'd1;
        end
        default: mp_state <= MP_IDLE;
      endcase
    end
  end

  // nP frame receiver: one ignored gap cycle, then N data bits MSB first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      np_state <= NP_IDLE;
      np_cnt   <= '0;
      io.o_nPx <= '0;
      io.o_nPy <= '0;
    end else begin
      case (np_state)
        NP_IDLE: begin
          if (io.i_nP_valid) np_state <= NP_GAP;
        end
        NP_GAP: begin
          io.o_nPx <= '0;
          io.o_nPy <= '0;
          np_cnt   <= last_idx(io.o_mode);
          np_state <= NP_DATA;
        end
        NP_DATA: begin
          io.o_nPx <= {io.o_nPx[MAX_BITS-2:0], io.i_nPx};
          io.o_nPy <= {io.o_nPy[MAX_BITS-2:0], io.i_nPy};
          if (np_cnt == 8'd0) np_state <= NP_IDLE;
          else                np_cnt   <= np_cnt - 8'd1;
        end
        default: np_state <= NP_IDLE;
      endcase
    end
  end

  // Start pulses; the ready flags are merged with this edge's completions so
  // frames finishing together start both operations in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io.o_start_mP  <= 1'b0;
      io.o_start_mnP <= 1'b0;
      mp_rdy         <= 1'b0;
      np_rdy         <= 1'b0;
    end else begin
      io.o_start_mP  <= mp_last;
      io.o_start_mnP <= 1'b0;
      if ((mp_rdy || mp_last) && (np_rdy || np_last)) begin
        io.o_start_mnP <= 1'b1;
        mp_rdy         <= 1'b0;
        np_rdy         <= 1'b0;
      end else begin
        mp_rdy <= mp_rdy || mp_last;
        np_rdy <= np_rdy || np_last;
      end
    end
  end

  // mP result serializer: latch on done, drive bit [cnt] down to bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mp_ser_state  <= SER_IDLE;
      mp_ser_cnt    <= '0;
      mp_sx         <= '0;
      mp_sy         <= '0;
      io.o_mP_valid <= 1'b0;
      io.o_mPx      <= 1'b0;
      io.o_mPy      <= 1'b0;
    end else begin
      io.o_mP_valid <= 1'b0;
      case (mp_ser_state)
        SER_IDLE: begin
          io.o_mPx <= 1'b0;
          io.o_mPy <= 1'b0;
          if (io.i_mP_done) begin
            mp_sx         <= io.i_mPx;
            mp_sy         <= io.i_mPy;
            mp_ser_cnt    <= ser_last;
            io.o_mP_valid <= 1'b1;
            io.o_mPx      <= io.i_mPx[ser_last];
            io.o_mPy      <= io.i_mPy[ser_last];
            mp_ser_state  <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (mp_ser_cnt == 8'd0) begin
            io.o_mPx     <= 1'b0;
            io.o_mPy     <= 1'b0;
            mp_ser_state <= SER_IDLE;
          end else begin
            io.o_mPx   <= mp_sx[mp_ser_cnt - 8'd1];
            io.o_mPy   <= mp_sy[mp_ser_cnt - 8'd1];
            mp_ser_cnt <= mp_ser_cnt - 8'd1;
          end
        end
        default: mp_ser_state <= SER_IDLE;
      endcase
    end
  end

  // mnP result serializer: independent copy of the mP serializer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mnp_ser_state  <= SER_IDLE;
      mnp_ser_cnt    <= '0;
      mnp_sx         <= '0;
      mnp_sy         <= '0;
      io.o_mnP_valid <= 1'b0;
      io.o_mnPx      <= 1'b0;
      io.o_mnPy      <= 1'b0;
    end else begin
      io.o_mnP_valid <= 1'b0;
      case (mnp_ser_state)
        SER_IDLE: begin
          io.o_mnPx <= 1'b0;
          io.o_mnPy <= 1'b0;
          if (io.i_mnP_done) begin
            mnp_sx         <= io.i_mnPx;
            mnp_sy         <= io.i_mnPy;
            mnp_ser_cnt    <= ser_last;
            io.o_mnP_valid <= 1'b1;
            io.o_mnPx      <= io.i_mnPx[ser_last];
            io.o_mnPy      <= io.i_mnPy[ser_last];
            mnp_ser_state  <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (mnp_ser_cnt == 8'd0) begin
            io.o_mnPx     <= 1'b0;
            io.o_mnPy     <= 1'b0;
            mnp_ser_state <= SER_IDLE;
          end else begin
            io.o_mnPx   <= mnp_sx[mnp_ser_cnt - 8'd1];
            io.o_mnPy   <= mnp_sy[mnp_ser_cnt - 8'd1];
            mnp_ser_cnt <= mnp_ser_cnt - 8'd1;
          end
        end
        default: mnp_ser_state <= SER_IDLE;
      endcase
    end
  end

`ifdef ECC_IO_PROTOCOL_CHK_EN
  logic err_evt;

  assign err_evt = (io.i_m_P_valid && (mp_state != MP_IDLE))
                || (io.i_nP_valid && (np_state != NP_IDLE))
                || (io.i_mP_done && (mp_ser_state == SER_SHIFT))
                || (io.i_mnP_done && (mnp_ser_state == SER_SHIFT))
                || (io.i_nP_valid && ((mp_state == MP_MODE_HI) ||
                                      (mp_state == MP_MODE_LO)));

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)         io.o_err <= 1'b0;
    else if (err_evt) io.o_err <= 1'b1;
  end
`else
  assign io.o_err = 1'b0;
`endif

endmodule
